// File: rtl/imm_rot_encoder.sv
// Multi-cycle encoder: finds the smallest rot and imm8 such that imm8 ROR (2*rot)
// reproduces a 32-bit constant, testing ROT_PER_CYCLE rotations per cycle.
module imm_rot_encoder #(
    parameter int ROT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [3:0]  rot,
    output logic [7:0]  imm8
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [4:0] STEP = 5'(ROT_PER_CYCLE);

    state_t      state_reg, state_next;
    logic [31:0] val_reg;
    logic [3:0]  cnt_reg;
    logic        valid_reg;
    logic [3:0]  rot_reg;
    logic [7:0]  imm8_reg;

    logic [ROT_PER_CYCLE-1:0] hit;
    logic [7:0]               cand_imm [ROT_PER_CYCLE];
    logic                     any_hit;
    logic [3:0]               hit_rot;
    logic [7:0]               hit_imm;
    logic                     last_chunk;

    // Rotating left by 2r undoes the decoder's right-rotate; a hit leaves only 8 live bits.
    genvar gi;
    generate
        for (gi = 0; gi < ROT_PER_CYCLE; gi++) begin : g_cand
            logic [3:0]  r;
            logic [5:0]  sh;
            logic [31:0] rolled;
            assign r             = cnt_reg + 4'(gi);
            assign sh            = {1'b0, r, 1'b0};
            assign rolled        = (val_reg << sh) | (val_reg >> (6'd32 - sh));
            assign hit[gi]       = (rolled[31:8] == 24'd0);
            assign cand_imm[gi]  = rolled[7:0];
        end
    endgenerate

    // Scan from the top down so the lowest hitting rotation is the one left standing.
    always_comb begin
        any_hit = 1'b0;
        hit_rot = '0;
        hit_imm = '0;
        for (int i = ROT_PER_CYCLE - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                hit_rot = cnt_reg + 4'(i);
                hit_imm = cand_imm[i];
            end
        end
    end

    assign last_chunk = (({1'b0, cnt_reg} + STEP) == 5'd16);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SEARCH;
            SEARCH:  if (any_hit || last_chunk) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            rot_reg   <= '0;
            imm8_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        val_reg <= value;
                        cnt_reg <= '0;
                    end
                end
                SEARCH: begin
                    if (any_hit) begin
                        valid_reg <= 1'b1;
                        rot_reg   <= hit_rot;
                        imm8_reg  <= hit_imm;
                    end else if (last_chunk) begin
                        valid_reg <= 1'b0;
                        rot_reg   <= '0;
                        imm8_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + STEP[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = valid_reg;
    assign rot   = rot_reg;
    assign imm8  = imm8_reg;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Drives three encoders (1, 4 and 16 rotations per cycle) with shared stimulus and
// scores every result against a brute-force search over all (rot, imm8) pairs.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;

    logic [2:0]  busy_w, done_w, valid_w;
    logic [3:0]  rot_w [3];
    logic [7:0]  imm_w [3];

    always #5 clk = ~clk;

    imm_rot_encoder #(.ROT_PER_CYCLE(1)) u_r1 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_w[0]), .done(done_w[0]), .valid(valid_w[0]), .rot(rot_w[0]), .imm8(imm_w[0]));
    imm_rot_encoder #(.ROT_PER_CYCLE(4)) u_r4 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_w[1]), .done(done_w[1]), .valid(valid_w[1]), .rot(rot_w[1]), .imm8(imm_w[1]));
    imm_rot_encoder #(.ROT_PER_CYCLE(16)) u_r16 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_w[2]), .done(done_w[2]), .valid(valid_w[2]), .rot(rot_w[2]), .imm8(imm_w[2]));

    typedef struct {
        logic [31:0] v;
        logic        ok;
        logic [3:0]  r;
        logic [7:0]  i;
        int          acc;
        int          done_at;
    } exp_t;

    exp_t sb [3][$];
    exp_t hold [3];
    int   next_free [3];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   armed = 1'b0;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        int m;
        m = s % 32;
        if (m == 0) return x;
        return (x >> m) | (x << (32 - m));
    endfunction

    // Exhaustive search: the first (lowest rot) pair that reproduces v wins.
    function automatic void model(input logic [31:0] v, output logic ok,
                                  output logic [3:0] r, output logic [7:0] i);
        ok = 1'b0;
        r  = '0;
        i  = '0;
        for (int rr = 15; rr >= 0; rr--) begin
            for (int ii = 255; ii >= 0; ii--) begin
                if (ror32(32'(ii), 2 * rr) == v) begin
                    ok = 1'b1;
                    r  = 4'(rr);
                    i  = 8'(ii);
                end
            end
        end
    endfunction

    function automatic int rpc(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 16;
    endfunction

    task automatic chk(input int k, input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL dut%0d %s got %h want %h (cycle %0d)", k, name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        logic [3:0] r;
        logic [7:0] i;
        int lat;
        cyc++;
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                if (sb[k].size() > 0 && sb[k][0].done_at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d done_timeout value %h expected done at cycle %0d", k, sb[k][0].v, sb[k][0].done_at);
                    void'(sb[k].pop_front());
                end
                chk(k, "busy", 32'(busy_w[k]), 32'(sb[k].size() > 0 && cyc >= sb[k][0].acc));
                if (done_w[k]) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected_done got done=1 want done=0 (cycle %0d)", k, cyc);
                    end else begin
                        e = sb[k].pop_front();
                        chk(k, "done_cycle", 32'(cyc), 32'(e.done_at));
                        hold[k] = e;
                        if (valid_w[k])
                            chk(k, "ror_invariant", ror32(32'(imm_w[k]), 2 * int'(rot_w[k])), e.v);
                        $display("dut%0d value %h -> valid %0d rot %0d imm8 %h (latency %0d)",
                                 k, e.v, valid_w[k], rot_w[k], imm_w[k], cyc - e.acc + 2);
                    end
                end
                chk(k, "valid", 32'(valid_w[k]), 32'(hold[k].ok));
                chk(k, "rot", 32'(rot_w[k]), 32'(hold[k].r));
                chk(k, "imm8", 32'(imm_w[k]), 32'(hold[k].i));
            end
        end
        // Inputs now visible are sampled on the next rising edge (posedge cyc+1).
        if (!reset) begin
            armed = 1'b1;
            for (int k = 0; k < 3; k++) begin
                sb[k].delete();
                hold[k] = '{v: 32'd0, ok: 1'b0, r: 4'd0, i: 8'd0, acc: 0, done_at: 0};
                next_free[k] = cyc + 2;
            end
        end else if (armed && start) begin
            model(value, ok, r, i);
            for (int k = 0; k < 3; k++) begin
                if (cyc + 1 >= next_free[k]) begin
                    lat = ok ? (int'(r) / rpc(k) + 2) : (16 / rpc(k) + 1);
                    sb[k].push_back('{v: value, ok: ok, r: r, i: i, acc: cyc + 1, done_at: cyc + lat});
                    next_free[k] = cyc + 2 + lat;
                end
            end
        end
    end

    task automatic op(input logic [31:0] v);
        @(posedge clk);
        #1;
        start = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = $urandom;
        repeat (19) @(posedge clk);
    endtask

    logic [31:0] directed [8];

    initial begin
        logic [31:0] v;
        directed[0] = 32'h0000_00FF;
        directed[1] = 32'hFF00_0000;
        directed[2] = 32'hF000_000F;
        directed[3] = 32'h0000_0104;
        directed[4] = 32'h0000_0102;
        directed[5] = 32'h0000_0000;
        directed[6] = 32'h0000_03FC;
        directed[7] = 32'h8000_0001;
        reset = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int n = 0; n < 8; n++) op(directed[n]);

        // Reset lands in the fifth SEARCH cycle of a long (miss) search.
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'h0000_0102;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        op(32'h0000_0104);

        // start held high with a new value every cycle.
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            value = (n % 2 == 0) ? ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15))) : $urandom;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1: v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
                2:    v = $urandom;
                default: v = 32'($urandom_range(0, 1023));
            endcase
            op(v);
        end

        repeat (40) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
